keypad_event_scan: RTL and testbench
====================================

Name: keypad_event_scan

Overview:
- Upstream stage of the tic-tac-toe game logic. Scans the 3-column x 4-row keypad, synchronizes and debounces the row returns, and emits exactly one `key_valid` pulse with a 4-bit `key_code` per physical press.
- The game FSM consumes `key_valid`/`key_code` directly; `key_code` is never treated as a level-encoded key.

Parameters:
- CLK_DIV, 12500: clk cycles per scan tick (25 MHz -> 2 kHz tick).
- DB_TICKS, 4: consecutive identical ticks required to accept a press or a release. Legal range 1..15.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- key_row  in  4  raw row returns, active-high, bit0 = top row; asynchronous to clk.
- key_col  out  3  one-hot column drive, bit0 = left column.
- key_valid  out  1  one-clk pulse per accepted press.
- key_code  out  4  code of the last accepted press; updated in the same cycle as `key_valid`.
- key_held  out  1  high from `key_valid` until the release is accepted.

Behaviour:
- Reset (rst=0, async):
  - key_col=3'b001, key_valid=0, key_code=4'hF, key_held=0.
  - State SCAN, tick counter 0, debounce counter 0, synchronizer flops 0.
- Synchronizer: key_row passes through two flops (row_s). All decisions use row_s sampled on tick only.
- Tick:
  - Counter runs 0..CLK_DIV-1.
  - `tick` is high for one clk when the counter equals CLK_DIV-1, then the counter wraps to 0.
- Key code map, by (column, row):
  - col0: rows 0/1/2/3 = 1 / 4 / 7 / 10 (*).
  - col1: rows 0/1/2/3 = 2 / 5 / 8 / 0.
  - col2: rows 0/1/2/3 = 3 / 6 / 9 / 11 (#).
  - 4'hF = none.
- FSM, evaluated on tick only; the state holds between ticks:
  - SCAN:
    - row_s==0: rotate key_col 001->010->100->001.
    - row_s multi-hot: ignored, rotate as if row_s==0.
    - row_s one-hot: latch row_s as cand_row, freeze key_col, db_cnt=1. If DB_TICKS==1 go to PRESS, else go to DEBOUNCE.
  - DEBOUNCE:
    - row_s==cand_row: db_cnt+1. When db_cnt reaches DB_TICKS, go to PRESS.
    - Otherwise (bounce): clear db_cnt, advance key_col to the next column, go to SCAN.
  - PRESS (one clk, not tick-gated):
    - key_valid=1, key_code=map(key_col, cand_row), key_held=1.
    - Go to HOLD with db_cnt=0.
  - HOLD, column stays frozen:
    - row_s==0: db_cnt+1. When db_cnt reaches DB_TICKS, go to SCAN, key_held=0, and advance key_col.
    - row_s!=0: db_cnt=0. This covers both the held key and any added key; no new event is produced.
- key_valid is high for exactly one clk, one cycle after the tick that completes the debounce.
- Press latency from a stable row edge: 2 clk (sync) + up to 3 scan ticks + DB_TICKS ticks + 1 clk.
- Second key pressed while the first is held: produces no event. It is detected only after the full release and a rescan.
- key_code is unchanged in every state except PRESS.
- Reset asserted mid-debounce or mid-hold: everything returns to reset values immediately. No pulse is emitted on reset release, even if a key is held; the held key is reported only after it passes a fresh debounce from SCAN.
- db_cnt is 4 bits and saturates at DB_TICKS; it never wraps.

Decomposition:
- Shared package `ttt_pkg`:
  - State typedef: SCAN, DEBOUNCE, PRESS, HOLD.
  - Constants: KEY_STAR=4'd10, KEY_HASH=4'd11, KEY_NONE=4'hF.
  - Column one-hot constants COL0/COL1/COL2.
- One sub-module `scan_tick_gen`: a CLK_DIV divider producing the single-cycle `tick`. It is reused by the dot-matrix and 7-segment refresh dividers.

Test Plan (CLK_DIV=4, DB_TICKS=3):
- Reset check: hold rst low, then release; drive key_row=0 -> key_col cycles 001,010,100 every 4 clk; key_valid never asserts; key_code=4'hF.
- Clean press of key 5 (row=4'b0010 only while key_col=010, held 40 clk):
  - Exactly one key_valid pulse, with key_code=5.
  - key_held rises in the same cycle and falls 3 ticks after the release.
- Bounce: row=4'b0001 on col0 for 2 ticks, then 0 for 1 tick, then 1 tick, then 0 -> no key_valid; scanning resumes at col1.
- Star and hash presses:
  - row=4'b1000 on col0 -> key_code=10.
  - Same row on col2 -> key_code=11.
  - key_col is frozen throughout each press.
- Multi-hot rows: row=4'b0011 on col1 -> no event; rotation continues.
- Reset during HOLD with key 9 still held:
  - key_held=0, key_col=001, key_code=4'hF asynchronously.
  - After release of reset, key 9 yields one new key_valid with code 9 only after rescan plus 3 debounce ticks.

Source files
------------

// File: rtl/ttt_pkg.sv
// Shared types and constants for the tic-tac-toe front end.
// Holds the keypad scanner states, key codes, column one-hots and the key map.
package ttt_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESS    = 2'd2,
    HOLD     = 2'd3
  } key_state_t;

  localparam logic [3:0] KEY_STAR = 4'd10;
  localparam logic [3:0] KEY_HASH = 4'd11;
  localparam logic [3:0] KEY_NONE = 4'hF;

  localparam logic [2:0] COL0 = 3'b001;
  localparam logic [2:0] COL1 = 3'b010;
  localparam logic [2:0] COL2 = 3'b100;

  function automatic logic [2:0] next_col(input logic [2:0] col);
    return {col[1:0], col[2]};
  endfunction

  function automatic logic is_onehot4(input logic [3:0] row);
    return (row != 4'd0) && ((row & (row - 4'd1)) == 4'd0);
  endfunction

  // Keypad layout: rows top to bottom are 1-2-3, 4-5-6, 7-8-9, *-0-#.
  function automatic logic [3:0] key_map(input logic [2:0] col, input logic [3:0] row);
    logic [3:0] code;
    code = KEY_NONE;
    case (col)
      COL0: case (row)
              4'b0001: code = 4'd1;
              4'b0010: code = 4'd4;
              4'b0100: code = 4'd7;
              4'b1000: code = KEY_STAR;
              default: code = KEY_NONE;
            endcase
      COL1: case (row)
              4'b0001: code = 4'd2;
              4'b0010: code = 4'd5;
              4'b0100: code = 4'd8;
              4'b1000: code = 4'd0;
              default: code = KEY_NONE;
            endcase
      COL2: case (row)
              4'b0001: code = 4'd3;
              4'b0010: code = 4'd6;
              4'b0100: code = 4'd9;
              4'b1000: code = KEY_HASH;
              default: code = KEY_NONE;
            endcase
      default: code = KEY_NONE;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Free-running divider: one-cycle o_tick every CLK_DIV clocks.
// Shared by the keypad scanner and the display refresh logic.
module scan_tick_gen #(
  parameter int CLK_DIV = 12500
) (
  input  logic clk,
  input  logic rst_n,
  output logic o_tick
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tick = (r_cnt == CNT_LAST);

endmodule

// File: rtl/keypad_event_scan.sv
// 3x4 keypad scanner: synchronizes row returns, debounces press and release,
// and emits one key_valid pulse with key_code per physical press.
module keypad_event_scan
  import ttt_pkg::*;
#(
  parameter int CLK_DIV  = 12500,
  parameter int DB_TICKS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_row,
  output logic [2:0] key_col,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       key_held
);

  localparam logic [3:0] DB_LAST = 4'(DB_TICKS);

  logic       w_tick;
  logic [3:0] r_row_m;
  logic [3:0] r_row_s;

  key_state_t r_state,    w_state_nxt;
  logic [2:0] r_col,      w_col_nxt;
  logic [3:0] r_cand_row, w_cand_nxt;
  logic [3:0] r_db_cnt,   w_db_nxt;
  logic [3:0] r_key_code, w_code_nxt;
  logic [3:0] w_db_inc;

  scan_tick_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst),
    .o_tick(w_tick)
  );

  // Two-flop synchronizer: key_row is asynchronous to clk.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_row_m <= '0;
      r_row_s <= '0;
    end else begin
      r_row_m <= key_row;
      r_row_s <= r_row_m;
    end
  end

  // Saturating increment so the counter can never wrap back past DB_TICKS.
  assign w_db_inc = (r_db_cnt >= DB_LAST) ? r_db_cnt : r_db_cnt + 4'd1;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    w_state_nxt = r_state;
    w_col_nxt   = r_col;
    w_cand_nxt  = r_cand_row;
    w_db_nxt    = r_db_cnt;
    w_code_nxt  = r_key_code;

    case (r_state)
      SCAN: begin
        if (w_tick) begin
          if (is_onehot4(r_row_s)) begin
            w_cand_nxt  = r_row_s;
            w_db_nxt    = 4'd1;
            w_state_nxt = (DB_LAST == 4'd1) ? PRESS : DEBOUNCE;
          end else begin
            w_col_nxt = next_col(r_col);
          end
        end
      end
      DEBOUNCE: begin
        if (w_tick) begin
          if (r_row_s == r_cand_row) begin
            w_db_nxt = w_db_inc;
            if (w_db_inc == DB_LAST) w_state_nxt = PRESS;
          end else begin
            w_db_nxt    = 4'd0;
            w_col_nxt   = next_col(r_col);
            w_state_nxt = SCAN;
          end
        end
      end
      PRESS: begin
        w_db_nxt    = 4'd0;
        w_state_nxt = HOLD;
      end
      HOLD: begin
        if (w_tick) begin
          if (r_row_s == 4'd0) begin
            w_db_nxt = w_db_inc;
            if (w_db_inc == DB_LAST) begin
              w_db_nxt    = 4'd0;
              w_col_nxt   = next_col(r_col);
              w_state_nxt = SCAN;
            end
          end else begin
            w_db_nxt = 4'd0;
          end
        end
      end
      default: w_state_nxt = SCAN;
    endcase

    // The code register loads on the edge that enters PRESS, so it is valid alongside key_valid.
    if (w_state_nxt == PRESS) w_code_nxt = key_map(r_col, w_cand_nxt);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= SCAN;
      r_col      <= COL0;
      r_cand_row <= '0;
      r_db_cnt   <= '0;
      r_key_code <= KEY_NONE;
    end else begin
      r_state    <= w_state_nxt;
      r_col      <= w_col_nxt;
      r_cand_row <= w_cand_nxt;
      r_db_cnt   <= w_db_nxt;
      r_key_code <= w_code_nxt;
    end
  end

  assign key_col   = r_col;
  assign key_code  = r_key_code;
  assign key_valid = (r_state == PRESS);
  assign key_held  = (r_state == PRESS) || (r_state == HOLD);

endmodule

// File: tb/tb_keypad_event_scan.sv
// Directed bench for keypad_event_scan with a keypad model and an expected-code scoreboard.
module tb_keypad_event_scan;
  import ttt_pkg::*;

  localparam int CLK_DIV  = 4;
  localparam int DB_TICKS = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] key_row;
  logic [2:0] key_col;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_held;

  logic [11:0] pressed = '0;   // bit col*4+row
  logic [3:0]  exp_q[$];
  logic [3:0]  last_code = KEY_NONE;
  logic        prev_valid = 1'b0;
  int          checks = 0;
  int          errors = 0;
  int          n_valid = 0;

  keypad_event_scan #(
    .CLK_DIV (CLK_DIV),
    .DB_TICKS(DB_TICKS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .key_row  (key_row),
    .key_col  (key_col),
    .key_valid(key_valid),
    .key_code (key_code),
    .key_held (key_held)
  );

  always #5 clk = ~clk;

  // Keypad matrix: a pressed key connects its row to the driven column.
  always_comb begin
    key_row = '0;
    for (int c = 0; c < 3; c++)
      if (key_col[c]) key_row = key_row | pressed[c*4 +: 4];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: pop an expected code on each key_valid pulse.
  always begin
    @(posedge clk);
    #1;
    if (!rst) begin
      last_code  = KEY_NONE;
      prev_valid = 1'b0;
    end else begin
      if (key_valid) begin
        n_valid++;
        check("valid_single_cycle", 32'(prev_valid), 32'(1'b0));
        check("held_with_valid", 32'(key_held), 32'(1'b1));
        check("valid_expected", 32'(exp_q.size() > 0), 32'(1'b1));
        if (exp_q.size() > 0) begin
          last_code = exp_q.pop_front();
          check("key_code", 32'(key_code), 32'(last_code));
        end
      end else begin
        check("code_stable", 32'(key_code), 32'(last_code));
      end
      prev_valid = key_valid;
    end
  end

  task automatic wait_col(input logic [2:0] target);
    int n;
    n = 0;
    while (key_col === target && n < 16) begin @(negedge clk); n++; end
    n = 0;
    while (key_col !== target && n < 16) begin @(negedge clk); n++; end
    check("wait_col", 32'(key_col), 32'(target));
  endtask

  task automatic wait_held(input logic lvl, input int budget, output int waited);
    waited = 0;
    while (key_held !== lvl && waited < budget) begin @(negedge clk); waited++; end
    check(lvl ? "held_rise" : "held_fall", 32'(key_held), 32'(lvl));
  endtask

  task automatic press_cycle(input int c, input int r, input logic [3:0] code,
                             input int hold_clks, output int rel_lat);
    logic [2:0] col;
    logic       moved;
    int         v0, w;
    col = 3'b001 << c;
    wait_col(col);
    v0 = n_valid;
    pressed[c*4+r] = 1'b1;
    exp_q.push_back(code);
    wait_held(1'b1, 40, w);
    moved = 1'b0;
    for (int i = 0; i < hold_clks; i++) begin
      @(negedge clk);
      if (key_col !== col) moved = 1'b1;
    end
    check("col_frozen", 32'(moved), 32'(1'b0));
    check("held_during", 32'(key_held), 32'(1'b1));
    pressed[c*4+r] = 1'b0;
    wait_held(1'b0, 30, rel_lat);
    check("one_pulse", 32'(n_valid - v0), 32'd1);
    check("code_after_release", 32'(key_code), 32'(code));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "bench timeout");
  end

  initial begin
    int lat, w, v0;
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_col", 32'(key_col), 32'(3'b001));
    check("rst_valid", 32'(key_valid), 32'(1'b0));
    check("rst_code", 32'(key_code), 32'(4'hF));
    check("rst_held", 32'(key_held), 32'(1'b0));

    // Idle rotation: column advances on every 4th clock after reset release.
    rst = 1'b1;
    @(negedge clk);     check("rot_0", 32'(key_col), 32'(3'b001));
    repeat (4) @(negedge clk); check("rot_1", 32'(key_col), 32'(3'b010));
    repeat (4) @(negedge clk); check("rot_2", 32'(key_col), 32'(3'b100));
    repeat (4) @(negedge clk); check("rot_3", 32'(key_col), 32'(3'b001));
    check("idle_no_valid", 32'(n_valid), 32'd0);

    // Clean press of key 5; release accepted after 3 zero ticks (+2 clk sync).
    press_cycle(1, 1, 4'd5, 40, lat);
    check("release_latency_5", 32'(lat >= 11 && lat <= 14), 32'd1);

    // Bounce on key 1: two good ticks, then a zero tick aborts the debounce.
    wait_col(3'b001);
    v0 = n_valid;
    pressed[0] = 1'b1;
    repeat (8) @(negedge clk);
    pressed[0] = 1'b0;
    repeat (4) @(negedge clk);
    check("bounce_resume_col1", 32'(key_col), 32'(3'b010));
    check("bounce_not_held", 32'(key_held), 32'(1'b0));
    pressed[0] = 1'b1;
    repeat (4) @(negedge clk);
    pressed[0] = 1'b0;
    repeat (12) @(negedge clk);
    check("bounce_no_valid", 32'(n_valid - v0), 32'd0);

    // Star and hash sit on the bottom row of the outer columns.
    press_cycle(0, 3, KEY_STAR, 24, lat);
    check("release_latency_star", 32'(lat >= 11 && lat <= 14), 32'd1);
    press_cycle(2, 3, KEY_HASH, 24, lat);
    check("release_latency_hash", 32'(lat >= 11 && lat <= 14), 32'd1);

    // Two keys in column 1 give a multi-hot row: ignored, rotation continues.
    wait_col(3'b010);
    v0 = n_valid;
    pressed[5:4] = 2'b11;
    repeat (4) @(negedge clk);
    check("multihot_rotate", 32'(key_col), 32'(3'b100));
    check("multihot_not_held", 32'(key_held), 32'(1'b0));
    repeat (16) @(negedge clk);
    pressed[5:4] = 2'b00;
    repeat (8) @(negedge clk);
    check("multihot_no_valid", 32'(n_valid - v0), 32'd0);

    // Key 9 held through an asynchronous reset.
    wait_col(3'b100);
    pressed[10] = 1'b1;
    exp_q.push_back(4'd9);
    wait_held(1'b1, 40, w);
    repeat (6) @(negedge clk);
    #3 rst = 1'b0;
    #1;
    check("arst_held", 32'(key_held), 32'(1'b0));
    check("arst_col", 32'(key_col), 32'(3'b001));
    check("arst_code", 32'(key_code), 32'(4'hF));
    check("arst_valid", 32'(key_valid), 32'(1'b0));
    repeat (3) @(negedge clk);
    exp_q.push_back(4'd9);
    v0 = n_valid;
    rst = 1'b1;
    // Rescan reaches col2 on the 2nd tick, then 3 debounce ticks: press on the 5th tick edge.
    wait_held(1'b1, 40, w);
    check("rescan_latency", 32'(w), 32'd20);
    check("one_pulse_after_reset", 32'(n_valid - v0), 32'd1);
    pressed[10] = 1'b0;
    wait_held(1'b0, 30, w);

    repeat (4) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    check("total_pulses", 32'(n_valid), 32'd5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
